uart_tx: RTL and testbench
==========================

# uart_tx

Transmit half of the UART: host-side parallel writes are buffered in a small circular FIFO and serialized onto the line as 8N1 frames (optionally 8E1). It pairs with the receive path's FIFO and shares its status-flag semantics, so software sees symmetric Empty/Full/Overflow indications on both directions. Fully synchronous to `Clk`; only `Rst` is asynchronous.

## Interface

Parameters:
- `DATA_BITS`, default 8: payload bits per frame.
- `FIFO_DEPTH`, default 4: number of entries in the transmit FIFO; power of two, at least 2.
- `CLKS_PER_BIT`, default 16: `Clk` cycles per serial bit; at least 2.

Ports:
- `Clk`, input, 1: system clock, rising edge.
- `Rst`, input, 1: reset, asynchronous, active-high.
- `Tx_Data`, input, `DATA_BITS`: byte to transmit; sampled when `Tx_Wr` is high.
- `Tx_Wr`, input, 1: write strobe; one entry is written per cycle that it is high.
- `BIST_Mode`, input, 1: high means host writes are ignored and no new frame starts.
- `Tx_Serial`, output, 1: serial line, registered, idles high.
- `Tx_Busy`, output, 1: high while any frame bit is being driven.
- `Tx_Done`, output, 1: one-cycle pulse in the last cycle of each stop bit.
- `FIFO_Empty`, output, 1: FIFO count is 0.
- `FIFO_Full`, output, 1: FIFO count equals `FIFO_DEPTH`.
- `FIFO_Overflow`, output, 1: sticky; set when a write is dropped because the FIFO is full.

## Operation

FIFO:
- Write pointer, read pointer and count are each `$clog2(FIFO_DEPTH)+1` bits wide. Pointers wrap modulo `FIFO_DEPTH`.
- A write is accepted when `Tx_Wr` is high, `BIST_Mode` is low, and the count before the edge is less than `FIFO_DEPTH`.
- A write to a full FIFO is dropped: contents and pointers are unchanged, and `FIFO_Overflow` is set. `FIFO_Overflow` clears only on `Rst`.
- When a write and a pop happen in the same cycle, the count is unchanged and both pointers advance. A write in the same cycle that a full FIFO pops is still dropped, because fullness is judged on the pre-edge count.
- `FIFO_Empty` and `FIFO_Full` are registered and reflect the count after the edge.

Frame state machine (IDLE, START, DATA, PARITY, STOP):
- IDLE: `Tx_Serial` is 1. If count is not 0 and `BIST_Mode` is low, pop the head entry into the shift register, clear the bit counter and baud counter, and go to START.
- START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: drive shift register bit 0 (LSB first), shifting right every `CLKS_PER_BIT` cycles. After `DATA_BITS` bits, go to PARITY if it is compiled in, otherwise STOP.
- PARITY: drive the XOR of all data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: drive 1 for `CLKS_PER_BIT` cycles; `Tx_Done` pulses in the last cycle. On that same edge, if count is not 0 and `BIST_Mode` is low, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- The baud counter runs from 0 to `CLKS_PER_BIT-1` and wraps. State changes occur on the wrap.
- `Tx_Busy` is high in every state except IDLE.
- If `BIST_Mode` rises mid-frame, the current frame completes normally.

Reset:
- Asserting `Rst` at any time forces: `Tx_Serial`=1, `Tx_Busy`=0, `Tx_Done`=0, `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0, state IDLE, pointers and count 0, FIFO contents 0.
- A partially sent frame is abandoned; the line returns high immediately.

## Timing

- A write on edge N into an idle, empty block gives count=1 after N. The pop happens on edge N+1, and `Tx_Serial` falls to 0 after edge N+1. Write-to-start-bit latency is 2 edges.
- Frame length in `Clk` cycles is (`DATA_BITS`+2)×`CLKS_PER_BIT`, plus `CLKS_PER_BIT` when parity is enabled. With defaults: 160 cycles without parity, 176 with parity.
- The pop edge and the START entry coincide, so a slot frees on the edge the frame begins.
- `Tx_Done` is high for exactly 1 cycle per frame, coincident with the last `Clk` cycle of the stop bit.

## Configuration

- `UART_TX_PARITY_EN` defined: the PARITY state exists and each frame carries one even-parity bit between the data bits and the stop bit.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

## Test plan

- Reset, then idle for 50 cycles: `Tx_Serial`=1, `FIFO_Empty`=1, `Tx_Busy`=0 throughout.
- Write 0xA5 once: `Tx_Serial` falls 2 edges later. Sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). Parity build: even-parity bit 0 inserted before the stop bit. `Tx_Done` pulses once, at cycle 160 (176 with parity).
- Write 0x01, 0x02, 0x03 on consecutive cycles: three frames are sent back-to-back with no idle cycle between stop and start. `FIFO_Empty` rises on the pop edge of the third frame.
- With the FSM busy, write 6 entries on consecutive cycles (`FIFO_DEPTH`=4, first frame already popped): 4 are accepted, `FIFO_Full`=1, the 5th and 6th are dropped, and `FIFO_Overflow`=1 and stays set until `Rst`.
- Hold `BIST_Mode`=1 and write 0x55: the FIFO stays empty and the line stays high. Raise `BIST_Mode` mid-frame: the current frame completes, and queued data is held until `BIST_Mode`=0.
- Assert `Rst` in the middle of the DATA state: `Tx_Serial`=1 immediately, all flags return to their reset values, and a subsequent write 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: transmit half of the UART.
// Host writes are queued in a circular FIFO and sent as 8N1 frames, or as 8E1
// frames when UART_TX_PARITY_EN is defined.
// Empty/Full/Overflow flags behave the same way as the receive-side FIFO flags.
`timescale 1ns/1ps

module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Tx_Wr,
    input  logic                 BIST_Mode,
    output logic                 Tx_Serial,
    output logic                 Tx_Busy,
    output logic                 Tx_Done,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [PW-1:0] DEPTH_C   = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;

    // Frame engine
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic                 serial_q, serial_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 wr_acc;
    logic                 wr_drop;
    logic                 baud_wrap;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Write acceptance, pop request and FIFO next-state (fullness judged on pre-edge count)
    always_comb begin
        wr_acc    = Tx_Wr && !BIST_Mode && (count_q < DEPTH_C);
        wr_drop   = Tx_Wr && !BIST_Mode && (count_q == DEPTH_C);
        baud_wrap = (baud_cnt_q == BAUD_LAST);
        pop       = (count_q != '0) && !BIST_Mode &&
                    ((state_q == IDLE) || ((state_q == STOP) && baud_wrap));
        head      = mem_q[rd_ptr_q[AW-1:0]];

        mem_d = mem_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q[AW-1:0]] = Tx_Data;
        end

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d    = count_q + PW'(wr_acc) - PW'(pop);
        empty_d    = (count_d == '0);
        full_d     = (count_d == DEPTH_C);
        overflow_d = overflow_q | wr_drop;
    end

    // Frame state machine next-state and registered serial line value
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CW'(1);
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        serial_d   = 1'b1;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (pop) begin
                    shift_d   = head;
                    bit_cnt_d = '0;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^head;
`endif
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_wrap) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    if (pop) begin
                        shift_d   = head;
                        bit_cnt_d = '0;
                        state_d   = START;
`ifdef UART_TX_PARITY_EN
                        parity_d  = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line value is derived from the post-edge state so Tx_Serial can be a flop
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_d;
`endif
            default: serial_d = 1'b1;
        endcase
    end

    // FIFO registers, cleared (including contents) by asynchronous reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame engine registers; reset abandons any frame and returns the line high
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            serial_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            serial_q   <= serial_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign Tx_Serial     = serial_q;
    assign Tx_Busy       = (state_q != IDLE);
    assign Tx_Done       = (state_q == STOP) && baud_wrap;
    assign FIFO_Empty    = empty_q;
    assign FIFO_Full     = full_q;
    assign FIFO_Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (default parameters).
// Honors UART_TX_PARITY_EN for the expected frame layout.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int DB  = 8;
    localparam int DEP = 4;
    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = DB + 3;
`else
    localparam int FB = DB + 2;
`endif
    localparam int FRAME = FB * CPB;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [DB-1:0] Tx_Data;
    logic          Tx_Wr;
    logic          BIST_Mode;
    logic          Tx_Serial;
    logic          Tx_Busy;
    logic          Tx_Done;
    logic          FIFO_Empty;
    logic          FIFO_Full;
    logic          FIFO_Overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_tx #(
        .DATA_BITS   (DB),
        .FIFO_DEPTH  (DEP),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Tx_Data      (Tx_Data),
        .Tx_Wr        (Tx_Wr),
        .BIST_Mode    (BIST_Mode),
        .Tx_Serial    (Tx_Serial),
        .Tx_Busy      (Tx_Busy),
        .Tx_Done      (Tx_Done),
        .FIFO_Empty   (FIFO_Empty),
        .FIFO_Full    (FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow)
    );

    always #5 Clk = ~Clk;

    // Expected line bits, index 0 = start bit, last index = stop bit
    function automatic logic [FB-1:0] exp_frame(input logic [DB-1:0] d);
        logic [FB-1:0] f;
        f = '0;
        for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[DB+1] = ^d;
`endif
        f[FB-1] = 1'b1;
        return f;
    endfunction

    // Observe one frame; the pop edge must be the next rising edge
    task automatic capture_frame(output logic [FB-1:0] bits, output int done_cnt,
                                 output int done_pos, output logic first,
                                 output int busy_low, output logic empty1);
        bits = '0; done_cnt = 0; done_pos = 0; busy_low = 0; first = 1'bx; empty1 = 1'bx;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge Clk);
            if (j == 1) begin
                first  = Tx_Serial;
                empty1 = FIFO_Empty;
            end
            if (((j - 1) % CPB) == CPB / 2) bits[(j-1)/CPB] = Tx_Serial;
            if (Tx_Done === 1'b1) begin
                done_cnt++;
                done_pos = j;
            end
            if (Tx_Busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic write_one(input logic [DB-1:0] d);
        @(negedge Clk);
        Tx_Wr = 1'b1; Tx_Data = d;
        @(negedge Clk);
        Tx_Wr = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        Rst = 1'b1; Tx_Wr = 1'b0; Tx_Data = '0; BIST_Mode = 1'b0;
        repeat (2) @(negedge Clk);
        tests_run++;
        if ({Tx_Serial, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow} !== 6'b100100) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 100100",
                     {Tx_Serial, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow});
        end
        Rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge Clk);
            if (Tx_Serial !== 1'b1 || FIFO_Empty !== 1'b1 || Tx_Busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL idle_50: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_single();
        logic [FB-1:0] bits;
        logic [FB-1:0] want;
        int dc, dp, bl;
        logic first, e1;
`ifdef UART_TX_PARITY_EN
        want = 11'b10101001010;
`else
        want = 10'b1101001010;
`endif
        write_one(8'hA5);
        tests_run++;
        if (Tx_Serial !== 1'b1 || FIFO_Empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency1: serial=%b empty=%b expected serial=1 empty=0", Tx_Serial, FIFO_Empty);
        end
        capture_frame(bits, dc, dp, first, bl, e1);
        tests_run++;
        if (first !== 1'b0 || e1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_start: serial=%b empty=%b expected serial=0 empty=1", first, e1);
        end
        tests_run++;
        if (bits !== want) begin
            tests_failed++;
            $display("FAIL single_bits: got %b expected %b", bits, want);
        end
        tests_run++;
        if (dc != 1 || dp != FRAME || bl != 0) begin
            tests_failed++;
            $display("FAIL single_done: count=%0d pos=%0d busy_low=%0d expected 1 %0d 0", dc, dp, bl, FRAME);
        end
        @(negedge Clk);
        tests_run++;
        if (Tx_Serial !== 1'b1 || Tx_Busy !== 1'b0 || FIFO_Empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_after: serial=%b busy=%b empty=%b expected 1 0 1", Tx_Serial, Tx_Busy, FIFO_Empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] b1, b2, b3;
        int dc1, dc2, dc3, dp1, dp2, dp3, bl1, bl2, bl3;
        logic f1, f2, f3, e1, e2, e3;
        @(negedge Clk);
        Tx_Wr = 1'b1; Tx_Data = 8'h01;
        @(negedge Clk);
        fork
            capture_frame(b1, dc1, dp1, f1, bl1, e1);
            begin
                Tx_Data = 8'h02;
                @(negedge Clk);
                Tx_Data = 8'h03;
                @(negedge Clk);
                Tx_Wr = 1'b0;
            end
        join
        capture_frame(b2, dc2, dp2, f2, bl2, e2);
        capture_frame(b3, dc3, dp3, f3, bl3, e3);
        tests_run++;
        if (b1 !== exp_frame(8'h01) || b2 !== exp_frame(8'h02) || b3 !== exp_frame(8'h03)) begin
            tests_failed++;
            $display("FAIL b2b_bits: got %b %b %b expected %b %b %b", b1, b2, b3,
                     exp_frame(8'h01), exp_frame(8'h02), exp_frame(8'h03));
        end
        tests_run++;
        if (f1 !== 1'b0 || f2 !== 1'b0 || f3 !== 1'b0 || bl1 != 0 || bl2 != 0 || bl3 != 0) begin
            tests_failed++;
            $display("FAIL b2b_gap: first=%b%b%b busy_low=%0d/%0d/%0d expected 000 0/0/0", f1, f2, f3, bl1, bl2, bl3);
        end
        tests_run++;
        if (e1 !== 1'b0 || e2 !== 1'b0 || e3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_empty: got %b%b%b expected 001", e1, e2, e3);
        end
        tests_run++;
        if (dc1 != 1 || dc2 != 1 || dc3 != 1 || dp3 != FRAME) begin
            tests_failed++;
            $display("FAIL b2b_done: counts %0d %0d %0d pos %0d expected 1 1 1 %0d", dc1, dc2, dc3, dp3, FRAME);
        end
    endtask

    task automatic test_overflow();
        logic [FB-1:0] b;
        logic [DB-1:0] vals [6];
        int dc, dp, bl;
        logic f, e;
        int bad_frames;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'h66;
        write_one(8'h5A);
        fork
            capture_frame(b, dc, dp, f, bl, e);
            begin
                @(negedge Clk);
                for (int i = 0; i < 6; i++) begin
                    Tx_Wr = 1'b1; Tx_Data = vals[i];
                    @(negedge Clk);
                    if (i == 3) begin
                        tests_run++;
                        if (FIFO_Full !== 1'b1 || FIFO_Overflow !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL ovf_fourth: full=%b ovf=%b expected 1 0", FIFO_Full, FIFO_Overflow);
                        end
                    end
                    if (i == 4) begin
                        tests_run++;
                        if (FIFO_Full !== 1'b1 || FIFO_Overflow !== 1'b1) begin
                            tests_failed++;
                            $display("FAIL ovf_fifth: full=%b ovf=%b expected 1 1", FIFO_Full, FIFO_Overflow);
                        end
                    end
                end
                Tx_Wr = 1'b0;
            end
        join
        tests_run++;
        if (b !== exp_frame(8'h5A) || dc != 1) begin
            tests_failed++;
            $display("FAIL ovf_first: bits=%b done=%0d expected %b 1", b, dc, exp_frame(8'h5A));
        end
        bad_frames = 0;
        for (int k = 0; k < 4; k++) begin
            capture_frame(b, dc, dp, f, bl, e);
            if (b !== exp_frame(vals[k]) || dc != 1 || f !== 1'b0) bad_frames++;
        end
        tests_run++;
        if (bad_frames != 0) begin
            tests_failed++;
            $display("FAIL ovf_drain: %0d bad frames, expected 0", bad_frames);
        end
        repeat (3) @(negedge Clk);
        tests_run++;
        if (Tx_Busy !== 1'b0 || Tx_Serial !== 1'b1 || FIFO_Empty !== 1'b1 || FIFO_Overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_idle: busy=%b serial=%b empty=%b ovf=%b expected 0 1 1 1",
                     Tx_Busy, Tx_Serial, FIFO_Empty, FIFO_Overflow);
        end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        tests_run++;
        if (FIFO_Overflow !== 1'b0 || FIFO_Empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b empty=%b expected 0 1", FIFO_Overflow, FIFO_Empty);
        end
    endtask

    task automatic test_bist();
        logic [FB-1:0] b;
        int dc, dp, bl, bad;
        logic f, e;
        BIST_Mode = 1'b1;
        @(negedge Clk);
        Tx_Wr = 1'b1; Tx_Data = 8'h55;
        repeat (3) @(negedge Clk);
        Tx_Wr = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge Clk);
            if (FIFO_Empty !== 1'b1 || Tx_Serial !== 1'b1 || Tx_Busy !== 1'b0 || FIFO_Overflow !== 1'b0) bad++;
        end
        BIST_Mode = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            if (FIFO_Empty !== 1'b1 || Tx_Busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bist_ignore: %0d bad cycles, expected 0", bad);
        end
        @(negedge Clk);
        Tx_Wr = 1'b1; Tx_Data = 8'h11;
        @(negedge Clk);
        fork
            capture_frame(b, dc, dp, f, bl, e);
            begin
                Tx_Data = 8'h22;
                @(negedge Clk);
                Tx_Wr = 1'b0;
                repeat (20) @(negedge Clk);
                BIST_Mode = 1'b1;
            end
        join
        tests_run++;
        if (b !== exp_frame(8'h11) || dc != 1 || dp != FRAME) begin
            tests_failed++;
            $display("FAIL bist_midframe: bits=%b done=%0d pos=%0d expected %b 1 %0d", b, dc, dp, exp_frame(8'h11), FRAME);
        end
        bad = 0;
        repeat (50) begin
            @(negedge Clk);
            if (Tx_Serial !== 1'b1 || Tx_Busy !== 1'b0 || FIFO_Empty !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bist_hold: %0d bad cycles, expected 0", bad);
        end
        BIST_Mode = 1'b0;
        capture_frame(b, dc, dp, f, bl, e);
        tests_run++;
        if (b !== exp_frame(8'h22) || dc != 1 || f !== 1'b0 || e !== 1'b1) begin
            tests_failed++;
            $display("FAIL bist_release: bits=%b done=%0d first=%b empty=%b expected %b 1 0 1",
                     b, dc, f, e, exp_frame(8'h22));
        end
    endtask

    task automatic test_midreset();
        logic [FB-1:0] b;
        int dc, dp, bl, bad;
        logic f, e;
        write_one(8'h3C);
        Tx_Wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Tx_Data = DB'(8'hC0 + i);
            @(negedge Clk);
        end
        Tx_Wr = 1'b0;
        repeat (55) @(negedge Clk);
        tests_run++;
        if (Tx_Busy !== 1'b1 || FIFO_Full !== 1'b1 || FIFO_Overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_precond: busy=%b full=%b ovf=%b expected 1 1 1", Tx_Busy, FIFO_Full, FIFO_Overflow);
        end
        #2;
        Rst = 1'b1;
        #1;
        tests_run++;
        if ({Tx_Serial, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow} !== 6'b100100) begin
            tests_failed++;
            $display("FAIL rst_async: got %b expected 100100",
                     {Tx_Serial, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow});
        end
        @(negedge Clk);
        Rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge Clk);
            if (Tx_Serial !== 1'b1 || Tx_Busy !== 1'b0 || FIFO_Empty !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rst_idle: %0d bad cycles, expected 0", bad);
        end
        write_one(8'h3C);
        capture_frame(b, dc, dp, f, bl, e);
        tests_run++;
        if (b !== exp_frame(8'h3C) || dc != 1 || dp != FRAME || f !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_retx: bits=%b done=%0d pos=%0d first=%b expected %b 1 %0d 0",
                     b, dc, dp, f, exp_frame(8'h3C), FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_bist();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
